// File: rtl/soc_boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, default
// frame start byte and the byte offsets of the frame header fields.
package soc_boot_pkg;

  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    LEN0       = 3'd1,
    LEN1       = 3'd2,
    DATA       = 3'd3,
    WRITE      = 3'd4,
    CHK        = 3'd5,
    DONE       = 3'd6
  } boot_state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Frame layout: MAGIC, LEN_LO, LEN_HI, LEN*4 data bytes, CHK
  localparam int OFS_MAGIC      = 0;
  localparam int OFS_LEN_LO     = 1;
  localparam int OFS_LEN_HI     = 2;
  localparam int OFS_DATA       = 3;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/soc_uart_boot_rx.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
// byte_vld and frame_err are single-cycle pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | timing to the middle of the start bit, reject glitches
// RX_BITS  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling the stop bit, emit byte or framing error
module soc_uart_boot_rx
  import soc_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       rx_byte_n;
  logic             byte_vld_n, frame_err_n;
  logic             rx_meta, rx_s;

  // Bring the asynchronous line into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_byte   <= rx_byte_n;
      byte_vld  <= byte_vld_n;
      frame_err <= frame_err_n;
    end
  end

  // Bit timing: down-counter reloaded each bit, sample on terminal count
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_byte_n   = rx_byte;
    byte_vld_n  = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = HALF_TC;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!rx_s) begin
          state_n   = RX_BITS;
          cnt_n     = BIT_TC;
          bit_idx_n = '0;
        end else begin
          state_n = RX_IDLE;
        end
      end
      RX_BITS: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = BIT_TC;
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = RX_IDLE;
          if (rx_s) begin
            byte_vld_n = 1'b1;
            rx_byte_n  = shreg;
          end else begin
            frame_err_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/soc_uart_boot.sv
// UART boot loader. Receives MAGIC, LEN_LO, LEN_HI, LEN little-endian words
// and a CHK byte, writes the words into BRAM over the stb/ack bus, then
// releases the CPU. Optional macro BOOT_CHKSUM_EN enables CHK comparison
// against the XOR of all LEN and data bytes; without it CHK is just consumed.
//
// state      | meaning
// WAIT_MAGIC | idle, timeout running, hunting for the start byte
// LEN0       | expecting the length low byte
// LEN1       | expecting the length high byte, range check
// DATA       | assembling the next 32-bit word
// WRITE      | word issued on the bus, waiting for ack
// CHK        | expecting the checksum byte
// DONE       | CPU released, terminal until reset
module soc_uart_boot
  import soc_boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 104,
  parameter int         ADDR_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        stb,
  input  logic        ack,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] dtw,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_TC    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(1 << WA_W);

  logic [7:0]  rx_byte;
  logic        byte_vld, frame_err;

  boot_state_t state, state_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [7:0]  len_lo, len_lo_n;
  logic [15:0] words_left, words_left_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [WA_W-1:0] word_addr, word_addr_n;
  logic [31:0] dtw_n;
  logic        stb_n, rw_n, cpu_hold_n, done_n, err_n;
  logic [7:0]  hold, hold_n;
  logic        hold_vld, hold_vld_n;
`ifdef BOOT_CHKSUM_EN
  logic [7:0]  chk_acc, chk_n;
`endif

  logic        in_vld;
  logic [7:0]  in_byte;
  logic [15:0] len_full;

  // A held byte always goes first so byte order is preserved after a write
  assign in_vld   = hold_vld | byte_vld;
  assign in_byte  = hold_vld ? hold : rx_byte;
  assign len_full = {in_byte, len_lo};
  assign addr     = {{(32-ADDR_WIDTH){1'b0}}, word_addr, 2'b00};

  soc_uart_boot_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_MAGIC;
      tmo_cnt    <= '0;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_addr  <= '0;
      dtw        <= '0;
      stb        <= 1'b0;
      rw         <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      hold       <= '0;
      hold_vld   <= 1'b0;
`ifdef BOOT_CHKSUM_EN
      chk_acc    <= '0;
`endif
    end else begin
      state      <= state_n;
      tmo_cnt    <= tmo_cnt_n;
      len_lo     <= len_lo_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      word_addr  <= word_addr_n;
      dtw        <= dtw_n;
      stb        <= stb_n;
      rw         <= rw_n;
      cpu_hold   <= cpu_hold_n;
      done       <= done_n;
      err        <= err_n;
      hold       <= hold_n;
      hold_vld   <= hold_vld_n;
`ifdef BOOT_CHKSUM_EN
      chk_acc    <= chk_n;
`endif
    end
  end

  // Frame sequencing, bus handshake and error handling
  always_comb begin
    state_n      = state;
    tmo_cnt_n    = tmo_cnt;
    len_lo_n     = len_lo;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    word_addr_n  = word_addr;
    dtw_n        = dtw;
    stb_n        = 1'b0;
    rw_n         = rw;
    cpu_hold_n   = cpu_hold;
    done_n       = done;
    err_n        = err;
    hold_n       = hold;
    hold_vld_n   = hold_vld;

    // Outside WRITE the holding register drains one byte per cycle
    if (state != WRITE) begin
      hold_vld_n = hold_vld & byte_vld;
      if (hold_vld & byte_vld) hold_n = rx_byte;
    end

    unique case (state)
      WAIT_MAGIC: begin
        if (in_vld && in_byte == MAGIC) begin
          err_n       = 1'b0;
          tmo_cnt_n   = '0;
          word_addr_n = '0;
          state_n     = LEN0;
        end else if (tmo_cnt == TMO_TC) begin
          state_n    = DONE;
          done_n     = 1'b1;
          cpu_hold_n = 1'b0;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      LEN0: begin
        if (in_vld) begin
          len_lo_n = in_byte;
          state_n  = LEN1;
        end
      end
      LEN1: begin
        if (in_vld) begin
          if (len_full == 16'd0) begin
            state_n = CHK;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            err_n       = 1'b1;
            word_addr_n = '0;
            state_n     = WAIT_MAGIC;
          end else begin
            words_left_n = len_full;
            byte_idx_n   = '0;
            state_n      = DATA;
          end
        end
      end
      DATA: begin
        if (in_vld) begin
          dtw_n[{byte_idx, 3'b000} +: 8] = in_byte;
          byte_idx_n = byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            stb_n   = 1'b1;
            rw_n    = 1'b1;
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        if (byte_vld && hold_vld) begin
          err_n       = 1'b1;
          rw_n        = 1'b0;
          hold_vld_n  = 1'b0;
          word_addr_n = '0;
          state_n     = WAIT_MAGIC;
        end else begin
          if (byte_vld) begin
            hold_n     = rx_byte;
            hold_vld_n = 1'b1;
          end
          if (ack) begin
            rw_n         = 1'b0;
            word_addr_n  = word_addr + 1'b1;
            words_left_n = words_left - 16'd1;
            byte_idx_n   = '0;
            state_n      = (words_left == 16'd1) ? CHK : DATA;
          end
        end
      end
      CHK: begin
        if (in_vld) begin
`ifdef BOOT_CHKSUM_EN
          if (in_byte == chk_acc) begin
            state_n    = DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            err_n       = 1'b1;
            word_addr_n = '0;
            state_n     = WAIT_MAGIC;
          end
`else
          state_n    = DONE;
          done_n     = 1'b1;
          cpu_hold_n = 1'b0;
`endif
        end
      end
      DONE: begin
        hold_vld_n = 1'b0;
      end
      default: state_n = WAIT_MAGIC;
    endcase

`ifdef BOOT_CHKSUM_EN
    // Running XOR over LEN and data bytes; held at zero between frames
    chk_n = chk_acc;
    if (state == WAIT_MAGIC)
      chk_n = '0;
    else if (in_vld && (state == LEN0 || state == LEN1 || state == DATA))
      chk_n = chk_acc ^ in_byte;
`endif

    // A bad stop bit aborts the frame from any state except DONE
    if (frame_err && state != DONE) begin
      err_n       = 1'b1;
      rw_n        = 1'b0;
      stb_n       = 1'b0;
      hold_vld_n  = 1'b0;
      word_addr_n = '0;
      state_n     = WAIT_MAGIC;
    end
  end

endmodule

// File: tb/tb_soc_uart_boot.sv
// Scoreboard bench for soc_uart_boot: directed frames, expected bus writes
// queued by the stimulus and compared by an independent stb monitor.
`timescale 1ns/1ps
module tb_soc_uart_boot;
  import soc_boot_pkg::*;

  localparam int CPB = 8;
  localparam int AW  = 12;
  localparam int TMO = 1000;

  logic        clk;
  logic        reset, rx, stb, ack, rw, cpu_hold, done, err;
  logic [31:0] addr, dtw;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  bit ack_en = 0;
  int ack_delay = 0;
  int stb_mark;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t        exp_q[$];
  wr_t        w;
  logic [7:0] frm[$];
  logic [31:0] a0, d0;

  soc_uart_boot #(
    .CLKS_PER_BIT   (CPB),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO),
    .MAGIC          (MAGIC_DEFAULT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .stb      (stb),
    .ack      (ack),
    .rw       (rw),
    .addr     (addr),
    .dtw      (dtw),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_raw(frm[i], 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    ack   = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every stb cycle must match the oldest expected write
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stb === 1'b1) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual_addr=%h actual_data=%h required=no_write", addr, dtw);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", addr, w.a);
          check("wr_data", dtw, w.d);
          check("wr_rw", 32'(rw), 32'd1);
        end
      end
    end
  end

  // BRAM responder: ack after ack_delay cycles, bus must hold still meanwhile
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stb === 1'b1 && ack_en) begin
        a0 = addr;
        d0 = dtw;
        repeat (ack_delay) begin
          @(posedge clk);
          #1;
          check("stb_pulse_width", 32'(stb), 32'd0);
          check("addr_stable", addr, a0);
          check("dtw_stable", dtw, d0);
          check("rw_pending", 32'(rw), 32'd1);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;

    // Reset values, then idle timeout boots the preloaded image
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_dtw", dtw, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_done_early", 32'(done), 32'd0);
    check("tmo_hold_early", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_cpu_hold", 32'(cpu_hold), 32'd0);
    check("tmo_no_stb", stb_cnt, 32'd0);

    // Two-word frame with correct checksum
    apply_reset();
    ack_en = 1; ack_delay = 2;
    exp_q.push_back('{32'h0, 32'hDEADBEEF});
    exp_q.push_back('{32'h4, 32'h12345678});
    frm = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h28};
    send_frame();
    repeat (4) @(negedge clk);
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_hold", 32'(cpu_hold), 32'd0);
    check("good_err", 32'(err), 32'd0);
    check("good_writes_left", exp_q.size(), 32'd0);
    stb_mark = stb_cnt;
    send_raw(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("done_ignores_rx", stb_cnt, stb_mark);
    check("done_sticky", 32'(done), 32'd1);

    // Same frame, checksum off by one bit
    apply_reset();
    exp_q.push_back('{32'h0, 32'hDEADBEEF});
    exp_q.push_back('{32'h4, 32'h12345678});
    frm[11] = 8'h29;
    send_frame();
    repeat (4) @(negedge clk);
    check("badchk_writes_left", exp_q.size(), 32'd0);
`ifdef BOOT_CHKSUM_EN
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_cpu_hold", 32'(cpu_hold), 32'd1);
    check("badchk_done", 32'(done), 32'd0);
    check("badchk_state", 32'(dut.state), 32'(WAIT_MAGIC));
    check("badchk_addr", addr, 32'd0);
`else
    check("badchk_done", 32'(done), 32'd1);
    check("badchk_cpu_hold", 32'(cpu_hold), 32'd0);
    check("badchk_err", 32'(err), 32'd0);
`endif

    // Oversized length is rejected after LEN_HI
    apply_reset();
    stb_mark = stb_cnt;
    frm = '{8'hA5, 8'hFF, 8'hFF};
    send_frame();
    repeat (2) @(negedge clk);
    check("len_err", 32'(err), 32'd1);
    check("len_state", 32'(dut.state), 32'(WAIT_MAGIC));
    check("len_cpu_hold", 32'(cpu_hold), 32'd1);
    check("len_no_stb", stb_cnt, stb_mark);

    // Zero-length frame goes straight to CHK
    apply_reset();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (2) @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_no_stb", stb_cnt, stb_mark);

    // One word, ack delayed five cycles
    apply_reset();
    ack_delay = 5;
    exp_q.push_back('{32'h0, 32'h44332211});
    frm = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_frame();
    repeat (4) @(negedge clk);
    check("slow_done", 32'(done), 32'd1);
    check("slow_err", 32'(err), 32'd0);
    check("slow_writes_left", exp_q.size(), 32'd0);

    // Overrun: ack withheld, CHK fills the hold register, one more byte overflows
    apply_reset();
    ack_en = 0;
    exp_q.push_back('{32'h0, 32'h44332211});
    frm = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_frame();
    check("ovr_pending_rw", 32'(rw), 32'd1);
    check("ovr_no_err_yet", 32'(err), 32'd0);
    send_raw(8'h99, 1'b1);
    repeat (2) @(negedge clk);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_state", 32'(dut.state), 32'(WAIT_MAGIC));
    check("ovr_addr", addr, 32'd0);
    check("ovr_rw", 32'(rw), 32'd0);
    check("ovr_cpu_hold", 32'(cpu_hold), 32'd1);
    check("ovr_writes_left", exp_q.size(), 32'd0);

    // Reset while the second word is pending; a late ack must do nothing
    apply_reset();
    exp_q.push_back('{32'h0, 32'hDEADBEEF});
    exp_q.push_back('{32'h4, 32'h12345678});
    frm = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    frm = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_frame();
    check("rstw_pending_rw", 32'(rw), 32'd1);
    check("rstw_pending_addr", addr, 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_stb", 32'(stb), 32'd0);
    check("rstw_addr", addr, 32'd0);
    check("rstw_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rstw_rw", 32'(rw), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stb_mark = stb_cnt;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_state", 32'(dut.state), 32'(WAIT_MAGIC));
    check("late_ack_addr", addr, 32'd0);
    check("late_ack_no_stb", stb_cnt, stb_mark);
    check("late_ack_done", 32'(done), 32'd0);

    // Bad stop bit aborts the frame; next MAGIC clears err
    apply_reset();
    send_raw(8'hA5, 1'b1);
    send_raw(8'h00, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("ferr_err", 32'(err), 32'd1);
    check("ferr_state", 32'(dut.state), 32'(WAIT_MAGIC));
    send_raw(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    check("magic_clears_err", 32'(err), 32'd0);
    check("magic_state", 32'(dut.state), 32'(LEN0));
    check("final_writes_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
